// File: rtl/game_pkg.sv
//==============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the game step scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    // Phase offsets from the start of a step
    localparam int PH_SPAWN = 0;
    localparam int PH_MOVE  = 1;
    localparam int PH_ANIM  = 2;

    // Phase offsets relative to the shift point H_OFF
    localparam int PH_SHIFT = 0;
    localparam int PH_CHECK = 1;
    localparam int PH_SHOW  = 2;

    localparam int P_NORMAL_DEF = 12_500_000;
    localparam int P_FAST_DEF   = 8_500_000;
    localparam int H_OFF_DEF    = 4_250_000;
    localparam int CNT_W_DEF    = 32;

endpackage

`default_nettype wire

// File: rtl/disp_handshake.sv
//==============================================================================
// Module      : disp_handshake
// Description : Frame request/ack handshake with timeout and sticky overrun.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module disp_handshake (
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_anim_fire,
    input  logic i_show_fire,
    input  logic i_anim_tmo,
    input  logic i_show_tmo,
    input  logic i_ack,
    output logic o_req,
    output logic o_sel,
    output logic o_ovf
);

    logic r_req;
    logic r_sel;
    logic r_ovf;
    logic w_tmo;

    // Deadline depends on which frame is outstanding
    assign w_tmo = r_sel ? i_show_tmo : i_anim_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= 1'b0;
            r_sel <= 1'b0;
            r_ovf <= 1'b0;
        end else if (i_flush) begin
            r_req <= 1'b0;
        end else begin
            if (r_req) begin
                if (i_ack) begin
                    r_req <= 1'b0;
                end else if (w_tmo) begin
                    r_req <= 1'b0;
                    r_ovf <= 1'b1;
                end
            end
            if (i_anim_fire) begin
                r_req <= 1'b1;
                r_sel <= 1'b0;
            end else if (i_show_fire) begin
                r_req <= 1'b1;
                r_sel <= 1'b1;
            end
        end
    end

    assign o_req = r_req;
    assign o_sel = r_sel;
    assign o_ovf = r_ovf;

endmodule

`default_nettype wire

// File: rtl/game_step_sched.sv
//==============================================================================
// Module      : game_step_sched
// Description : Step timer splitting each step into six phase strobes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module game_step_sched
    import game_pkg::*;
#(
    parameter int P_NORMAL = P_NORMAL_DEF,
    parameter int P_FAST   = P_FAST_DEF,
    parameter int H_OFF    = H_OFF_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pause,
    input  logic       speed,
    input  logic       gameover,
    input  logic       disp_ack,
    output logic       spawn_stb,
    output logic       move_stb,
    output logic       anim_stb,
    output logic       shift_stb,
    output logic       check_stb,
    output logic       show_stb,
    output logic       disp_req,
    output logic       disp_sel,
    output logic       over,
    output logic       ovf,
    output logic [7:0] step_cnt,
    output logic       running
);

    localparam logic [CNT_W-1:0] c_P_NORMAL = CNT_W'(P_NORMAL);
    localparam logic [CNT_W-1:0] c_P_FAST   = CNT_W'(P_FAST);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_T_SPAWN  = CNT_W'(PH_SPAWN);
    localparam logic [CNT_W-1:0] c_T_MOVE   = CNT_W'(PH_MOVE);
    localparam logic [CNT_W-1:0] c_T_ANIM   = CNT_W'(PH_ANIM);
    localparam logic [CNT_W-1:0] c_T_SHIFT  = CNT_W'(H_OFF + PH_SHIFT);
    localparam logic [CNT_W-1:0] c_T_CHECK  = CNT_W'(H_OFF + PH_CHECK);
    localparam logic [CNT_W-1:0] c_T_SHOW   = CNT_W'(H_OFF + PH_SHOW);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_tcnt;
    logic [CNT_W-1:0] w_tcnt_next;
    logic [CNT_W-1:0] r_pcur;
    logic [5:0]       r_dec;
    logic [5:0]       w_dec;
    logic [7:0]       r_step_cnt;
    logic             r_running;
    logic             r_over;
    logic             w_run;
    logic             w_adv;
    logic             w_wrap;
    logic             w_flush;
    logic             w_anim_tmo;
    logic             w_show_tmo;

    assign w_run  = (r_state == RUN);
    assign w_adv  = w_run & ~pause;
    assign w_wrap = w_adv & (r_tcnt == r_pcur - c_ONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (en) w_state_next = RUN;
            RUN: begin
                if (gameover)
                    w_state_next = OVER;
                else if (w_wrap && !en)
                    w_state_next = IDLE;
            end
            OVER:    w_state_next = OVER;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_tcnt_next = r_tcnt;
        if (w_state_next != RUN)
            w_tcnt_next = '0;
        else if (w_wrap)
            w_tcnt_next = '0;
        else if (w_adv)
            w_tcnt_next = r_tcnt + c_ONE;
    end

    // Phase decode is registered from the next count; pause only gates it out
    assign w_dec = (w_state_next != RUN) ? 6'b0 :
                   {w_tcnt_next == c_T_SPAWN, w_tcnt_next == c_T_MOVE,
                    w_tcnt_next == c_T_ANIM,  w_tcnt_next == c_T_SHIFT,
                    w_tcnt_next == c_T_CHECK, w_tcnt_next == c_T_SHOW};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tcnt     <= '0;
            r_pcur     <= c_P_NORMAL;
            r_dec      <= '0;
            r_step_cnt <= '0;
            r_running  <= 1'b0;
            r_over     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tcnt    <= w_tcnt_next;
            r_dec     <= w_dec;
            r_running <= (w_state_next == RUN);
            r_over    <= (w_state_next == OVER);
            if (w_adv && r_tcnt == '0)
                r_pcur <= speed ? c_P_FAST : c_P_NORMAL;
            if (shift_stb)
                r_step_cnt <= r_step_cnt + 8'd1;
        end
    end

    assign spawn_stb = r_dec[5] & ~pause;
    assign move_stb  = r_dec[4] & ~pause;
    assign anim_stb  = r_dec[3] & ~pause;
    assign shift_stb = r_dec[2] & ~pause;
    assign check_stb = r_dec[1] & ~pause;
    assign show_stb  = r_dec[0] & ~pause;

    // Deadlines are taken on the advancing edge into H_OFF / Pcur-1
    assign w_anim_tmo = w_adv & (r_tcnt == c_T_SHIFT - c_ONE);
    assign w_show_tmo = w_adv & (r_tcnt == r_pcur - c_TWO);
    assign w_flush    = (w_state_next != RUN);

    disp_handshake u_disp_handshake (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (w_flush),
        .i_anim_fire (anim_stb),
        .i_show_fire (show_stb),
        .i_anim_tmo  (w_anim_tmo),
        .i_show_tmo  (w_show_tmo),
        .i_ack       (disp_ack),
        .o_req       (disp_req),
        .o_sel       (disp_sel),
        .o_ovf       (ovf)
    );

    assign step_cnt = r_step_cnt;
    assign running  = r_running;
    assign over     = r_over;

endmodule

`default_nettype wire

// File: tb/tb_game_step_sched.sv
//==============================================================================
// Module      : tb_game_step_sched
// Description : Directed and random checks of game_step_sched against a model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_game_step_sched;

    localparam int PN = 40;
    localparam int PF = 24;
    localparam int HO = 16;

    logic clk, rst, en, pause, speed, gameover, disp_ack;
    logic spawn_stb, move_stb, anim_stb, shift_stb, check_stb, show_stb;
    logic disp_req, disp_sel, over, ovf, running;
    logic [7:0] step_cnt;
    logic [5:0] stbv;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: mode 0=idle 1=run 2=over, t = position in step
    int m_mode, m_t, m_per, m_steps;
    bit m_req, m_sel, m_ovf;
    int offs[6];

    game_step_sched #(.P_NORMAL(PN), .P_FAST(PF), .H_OFF(HO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .pause(pause), .speed(speed),
        .gameover(gameover), .disp_ack(disp_ack),
        .spawn_stb(spawn_stb), .move_stb(move_stb), .anim_stb(anim_stb),
        .shift_stb(shift_stb), .check_stb(check_stb), .show_stb(show_stb),
        .disp_req(disp_req), .disp_sel(disp_sel), .over(over), .ovf(ovf),
        .step_cnt(step_cnt), .running(running)
    );

    assign stbv = {spawn_stb, move_stb, anim_stb, shift_stb, check_stb, show_stb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] exp_stb();
        logic [5:0] s;
        s = '0;
        if (m_mode == 1 && !pause)
            for (int k = 0; k < 6; k++) s[5-k] = (m_t == offs[k]);
        return s;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_per = PN; m_steps = 0;
        m_req = 0; m_sel = 0; m_ovf = 0;
    endtask

    task automatic model_update();
        logic [5:0] s;
        bit adv;
        int nt, nmode;
        if (rst) begin
            model_reset();
            return;
        end
        s = exp_stb();
        adv = (m_mode == 1) && !pause;
        if (adv && m_t == 0) m_per = speed ? PF : PN;
        nt = m_t;
        nmode = m_mode;
        if (m_mode == 0) begin
            if (en) begin nmode = 1; nt = 0; end
        end else if (m_mode == 1) begin
            if (gameover) nmode = 2;
            else if (adv) begin
                if (m_t == m_per - 1) begin
                    nt = 0;
                    if (!en) nmode = 0;
                end else nt = m_t + 1;
            end
        end
        if (s[2]) m_steps = (m_steps + 1) % 256;
        if (nmode != 1) m_req = 0;
        else begin
            if (m_req) begin
                if (disp_ack) m_req = 0;
                else if (adv && nt == (m_sel ? m_per - 1 : HO)) begin
                    m_req = 0;
                    m_ovf = 1;
                end
            end
            if (s[3]) begin m_req = 1; m_sel = 0; end
            if (s[0]) begin m_req = 1; m_sel = 1; end
        end
        m_t = (nmode == 1) ? nt : 0;
        m_mode = nmode;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        chk("strobes", {26'd0, stbv}, {26'd0, exp_stb()});
        chk("disp", {29'd0, disp_req, disp_sel, ovf}, {29'd0, m_req, m_sel, m_ovf});
        chk("status", {30'd0, over, running}, {30'd0, m_mode == 2, m_mode == 1});
        chk("step_cnt", 32'(step_cnt), 32'(m_steps));
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Reset, then one IDLE cycle with en=1 so the next cycle is RUN with tcnt=0
    task automatic start_run(input logic ack);
        rst = 1'b1; en = 1'b0; pause = 1'b0; speed = 1'b0; gameover = 1'b0;
        disp_ack = ack;
        model_reset();
        settle();
        advance();
        rst = 1'b0;
        en  = 1'b1;
        settle();
        advance();
    endtask

    initial begin
        offs = '{0, 1, 2, HO, HO + 1, HO + 2};
        rst = 1'b1; en = 1'b0; pause = 1'b0; speed = 1'b0;
        gameover = 1'b0; disp_ack = 1'b0;
        model_reset();

        // Phase positions of the first step
        start_run(1'b1);
        for (int n = 0; n <= 41; n++) begin
            settle();
            chk($sformatf("phase_n%0d", n), {26'd0, stbv},
                {26'd0, n == 0 || n == 40, n == 1 || n == 41, n == 2, n == 16, n == 17, n == 18});
            if (n == 16) chk("step_before_shift", 32'(step_cnt), 32'd0);
            if (n == 17) chk("step_after_shift", 32'(step_cnt), 32'd1);
            advance();
        end

        // Speed change mid-step applies to the next step only
        start_run(1'b1);
        for (int n = 0; n <= 65; n++) begin
            if (n == 5) speed = 1'b1;
            settle();
            chk($sformatf("speed_spawn_n%0d", n), 32'(spawn_stb),
                32'(n == 0 || n == 40 || n == 64));
            advance();
        end

        // Pause for 10 cycles while tcnt sits at the shift point
        start_run(1'b1);
        for (int n = 0; n <= 51; n++) begin
            pause = (n >= 16 && n <= 25);
            settle();
            chk($sformatf("pause_shift_n%0d", n), 32'(shift_stb), 32'(n == 26));
            chk($sformatf("pause_spawn_n%0d", n), 32'(spawn_stb), 32'(n == 0 || n == 50));
            advance();
        end
        pause = 1'b0;

        // Unacknowledged animation frame times out
        start_run(1'b0);
        for (int n = 0; n <= 17; n++) begin
            settle();
            chk($sformatf("tmo_req_n%0d", n), 32'(disp_req), 32'(n >= 3 && n <= 15));
            chk($sformatf("tmo_ovf_n%0d", n), 32'(ovf), 32'(n >= 16));
            advance();
        end

        // Ack in the deadline cycle is an acceptance
        start_run(1'b0);
        for (int n = 0; n <= 20; n++) begin
            disp_ack = (n == 15);
            settle();
            chk($sformatf("late_ack_ovf_n%0d", n), 32'(ovf), 32'd0);
            if (n == 16) chk("late_ack_req", 32'(disp_req), 32'd0);
            advance();
        end
        disp_ack = 1'b0;

        // Game over freezes the scheduler
        start_run(1'b1);
        for (int n = 0; n <= 119; n++) begin
            gameover = (n == 18);
            settle();
            chk($sformatf("go_over_n%0d", n), 32'(over), 32'(n >= 19));
            if (n >= 19) chk($sformatf("go_quiet_n%0d", n), {26'd0, stbv}, 32'd0);
            if (n >= 17) chk($sformatf("go_steps_n%0d", n), 32'(step_cnt), 32'd1);
            advance();
        end
        gameover = 1'b0;

        // Dropping en lets the step finish, then idles
        start_run(1'b1);
        for (int n = 0; n <= 45; n++) begin
            en = (n < 20);
            settle();
            chk($sformatf("endrop_run_n%0d", n), 32'(running), 32'(n <= 39));
            chk($sformatf("endrop_spawn_n%0d", n), 32'(spawn_stb), 32'(n == 0));
            advance();
        end

        // Random traffic against the model, with periodic async reset
        for (int i = 0; i < 3000; i++) begin
            rst = (i % 600 == 0);
            if (rst) model_reset();
            en       = ($urandom_range(0, 19) != 0);
            pause    = ($urandom_range(0, 9) == 0);
            speed    = 1'($urandom_range(0, 1));
            gameover = ($urandom_range(0, 399) == 0);
            disp_ack = ($urandom_range(0, 3) == 0);
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
